// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions for the skid-buffered pipeline register:
// state encoding, default widths and a small occupancy helper.
package pipe_skid_reg_pkg;

   localparam int DEF_DATA_W = 72;
   localparam int DEF_CTRL_W = 4;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   // The state encoding is chosen so it doubles as the entry count.
   function automatic logic [1:0] state_occupancy(input skid_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used to track back-pressure cycles.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             INC,
   output logic [CNT_W-1:0] COUNT
);

   // Count requested cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         COUNT <= '0;
      end else if (INC && (COUNT != {CNT_W{1'b1}})) begin
         COUNT <= COUNT + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: a head (main) register plus a skid
// register kept in FIFO order, with a global freeze (BUSYWAIT), a
// synchronous discard (FLUSH) and a saturating back-pressure counter.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [CTRL_W-1:0] IN_CTRL,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [CTRL_W-1:0] OUT_CTRL,
   output logic [DATA_W-1:0] OUT_DATA,
   input  logic              BUSYWAIT,
   input  logic              FLUSH,
   output logic [1:0]        OCCUPANCY,
   output logic [CNT_W-1:0]  STALL_CNT
);

   skid_state_e       state;
   skid_state_e       next_state;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              pop;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;
   logic              stall_inc;

   // Ready and valid are pure decodes of the registered state, so no
   // combinational path exists from any input to IN_READY.
   assign IN_READY  = (state != ST_TWO);
   assign OUT_VALID = (state != ST_EMPTY);
   assign OCCUPANCY = state_occupancy(state);
   assign OUT_CTRL  = OUT_VALID ? main_ctrl : '0;
   assign OUT_DATA  = main_data;

   assign accept    = IN_VALID & IN_READY & ~BUSYWAIT & ~FLUSH;
   assign pop       = OUT_VALID & OUT_READY & ~BUSYWAIT & ~FLUSH;
   assign stall_inc = IN_VALID & ~accept & ~FLUSH;

   // State register; reset drops every held entry.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= ST_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and datapath load selects; FLUSH overrides everything.
   always_comb begin
      next_state     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               next_state   = ST_ONE;
               load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               next_state = ST_TWO;
               load_skid  = 1'b1;
            end else if (pop && !accept) begin
               next_state = ST_EMPTY;
            end else if (accept && pop) begin
               load_main_in = 1'b1;
            end
         end
         ST_TWO: begin
            if (pop) begin
               next_state     = ST_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            next_state = ST_EMPTY;
         end
      endcase
      if (FLUSH) begin
         next_state = ST_EMPTY;
      end
   end

   // Entry storage; the head refills from the input or the skid slot and
   // contents are left stale on flush since OUT_VALID masks them.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         if (load_main_in) begin
            main_ctrl <= IN_CTRL;
            main_data <= IN_DATA;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= IN_CTRL;
            skid_data <= IN_DATA;
         end
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .INC   (stall_inc),
      .COUNT (STALL_CNT)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, a few
// multi-cycle corner sequences and randomized traffic against a queue model.
module tb_pipe_skid_reg;

   logic        clock;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [3:0]  inCtrl;
   logic [71:0] inData;
   logic        outValid;
   logic        outReady;
   logic [3:0]  outCtrl;
   logic [71:0] outData;
   logic        busyWait;
   logic        flush;
   logic [1:0]  occupancy;
   logic [15:0] stallCnt;

   logic        inValid2;
   logic        inReady2;
   logic [3:0]  inCtrl2;
   logic [71:0] inData2;
   logic        outValid2;
   logic [3:0]  outCtrl2;
   logic [71:0] outData2;
   logic [1:0]  occupancy2;
   logic [1:0]  stallCnt2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        iv;
      logic [3:0]  ctrl;
      logic [71:0] data;
      logic        ordy;
      logic        bw;
      logic        fl;
      logic        ev;
      logic [3:0]  ectrl;
      logic [71:0] edata;
      logic        chkData;
      logic [1:0]  eocc;
      logic        erdy;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vecs[17];

   localparam logic [71:0] DA = 72'hA1_0000_0000_0000_00A1;
   localparam logic [71:0] DB = 72'hB2_1111_2222_3333_44B2;
   localparam logic [71:0] DC = 72'hC3_5555_6666_7777_88C3;
   localparam logic [71:0] DD = 72'hD4_9999_AAAA_BBBB_CCD4;
   localparam logic [71:0] DE = 72'hE5_DDDD_EEEE_FFFF_00E5;
   localparam logic [71:0] DF = 72'hF6_0123_4567_89AB_CDF6;
   localparam logic [71:0] DG = 72'h17_FEDC_BA98_7654_3217;
   localparam logic [71:0] DH = 72'h28_1357_9BDF_2468_AC28;
   localparam logic [71:0] DI = 72'h39_0F0F_F0F0_0F0F_F039;

   pipe_skid_reg dut (
      .CLK       (clock),
      .RESET     (reset),
      .IN_VALID  (inValid),
      .IN_READY  (inReady),
      .IN_CTRL   (inCtrl),
      .IN_DATA   (inData),
      .OUT_VALID (outValid),
      .OUT_READY (outReady),
      .OUT_CTRL  (outCtrl),
      .OUT_DATA  (outData),
      .BUSYWAIT  (busyWait),
      .FLUSH     (flush),
      .OCCUPANCY (occupancy),
      .STALL_CNT (stallCnt)
   );

   pipe_skid_reg #(.CNT_W(2)) dutSat (
      .CLK       (clock),
      .RESET     (reset),
      .IN_VALID  (inValid2),
      .IN_READY  (inReady2),
      .IN_CTRL   (inCtrl2),
      .IN_DATA   (inData2),
      .OUT_VALID (outValid2),
      .OUT_READY (1'b0),
      .OUT_CTRL  (outCtrl2),
      .OUT_DATA  (outData2),
      .BUSYWAIT  (1'b0),
      .FLUSH     (1'b0),
      .OCCUPANCY (occupancy2),
      .STALL_CNT (stallCnt2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic iv, input logic [3:0] ctrl, input logic [71:0] data,
                               input logic ordy, input logic bw, input logic fl,
                               input logic ev, input logic [3:0] ectrl, input logic [71:0] edata,
                               input logic chkData, input logic [1:0] eocc, input logic erdy,
                               input logic [15:0] ecnt);
      vec_t v;
      v.iv = iv; v.ctrl = ctrl; v.data = data; v.ordy = ordy; v.bw = bw; v.fl = fl;
      v.ev = ev; v.ectrl = ectrl; v.edata = edata; v.chkData = chkData;
      v.eocc = eocc; v.erdy = erdy; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [3:0] ctrl, input logic [71:0] data,
                                input logic ordy, input logic bw, input logic fl);
      inValid  = iv;
      inCtrl   = ctrl;
      inData   = data;
      outReady = ordy;
      busyWait = bw;
      flush    = fl;
      @(posedge clock);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic ev, input logic [3:0] ectrl,
                           input logic [71:0] edata, input logic chkData, input logic [1:0] eocc,
                           input logic erdy, input logic [15:0] ecnt);
      checkOutput({tag, " out_valid"}, 72'(outValid), 72'(ev));
      checkOutput({tag, " out_ctrl"}, 72'(outCtrl), 72'(ectrl));
      if (chkData) checkOutput({tag, " out_data"}, outData, edata);
      checkOutput({tag, " occupancy"}, 72'(occupancy), 72'(eocc));
      checkOutput({tag, " in_ready"}, 72'(inReady), 72'(erdy));
      checkOutput({tag, " stall_cnt"}, 72'(stallCnt), 72'(ecnt));
   endtask

   // Reference model: a plain FIFO of {ctrl,data} with capacity two.
   logic [75:0] modelQ[$];
   logic [15:0] modelCnt;

   task automatic modelStep(input logic iv, input logic [3:0] ctrl, input logic [71:0] data,
                            input logic ordy, input logic bw, input logic fl);
      bit canTake;
      bit hasHead;
      bit acc;
      bit pp;
      canTake = (modelQ.size() < 2);
      hasHead = (modelQ.size() > 0);
      acc = iv && canTake && !bw && !fl;
      pp  = hasHead && ordy && !bw && !fl;
      if (iv && !acc && !fl && modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      if (fl) begin
         modelQ.delete();
      end else begin
         if (pp) void'(modelQ.pop_front());
         if (acc) modelQ.push_back({ctrl, data});
      end
   endtask

   initial begin
      logic [95:0] r;
      logic        iv, ordy, bw, fl;
      logic [3:0]  ctrl;
      logic [71:0] data;
      logic [75:0] head;

      reset = 1'b0;
      inValid = 1'b0; inCtrl = '0; inData = '0; outReady = 1'b0; busyWait = 1'b0; flush = 1'b0;
      inValid2 = 1'b0; inCtrl2 = '0; inData2 = '0;

      // Directed table; each row is one clock edge.
      vecs[0]  = mk(1, 4'b1011, DA, 1, 0, 0, 1, 4'b1011, DA, 1, 2'd1, 1, 16'd0);
      vecs[1]  = mk(1, 4'b0110, DB, 0, 0, 0, 1, 4'b1011, DA, 1, 2'd2, 0, 16'd0);
      vecs[2]  = mk(1, 4'b0001, DC, 0, 0, 0, 1, 4'b1011, DA, 1, 2'd2, 0, 16'd1);
      vecs[3]  = mk(1, 4'b0001, DC, 0, 0, 0, 1, 4'b1011, DA, 1, 2'd2, 0, 16'd2);
      vecs[4]  = mk(0, 4'b0000, DC, 1, 0, 0, 1, 4'b0110, DB, 1, 2'd1, 1, 16'd2);
      vecs[5]  = mk(0, 4'b0000, DC, 1, 0, 0, 0, 4'b0000, DB, 0, 2'd0, 1, 16'd2);
      vecs[6]  = mk(1, 4'b1100, DD, 0, 0, 0, 1, 4'b1100, DD, 1, 2'd1, 1, 16'd2);
      vecs[7]  = mk(1, 4'b0011, DE, 0, 0, 0, 1, 4'b1100, DD, 1, 2'd2, 0, 16'd2);
      for (int i = 8; i < 13; i++)
         vecs[i] = mk(0, 4'b0000, DF, 1, 1, 0, 1, 4'b1100, DD, 1, 2'd2, 0, 16'd2);
      vecs[13] = mk(0, 4'b0000, DF, 1, 0, 0, 1, 4'b0011, DE, 1, 2'd1, 1, 16'd2);
      vecs[14] = mk(1, 4'b1111, DF, 0, 0, 0, 1, 4'b0011, DE, 1, 2'd2, 0, 16'd2);
      vecs[15] = mk(1, 4'b1010, DG, 1, 1, 1, 0, 4'b0000, DE, 0, 2'd0, 1, 16'd2);
      vecs[16] = mk(1, 4'b0101, DG, 0, 0, 0, 1, 4'b0101, DG, 1, 2'd1, 1, 16'd2);

      // Values while reset is held low.
      #13;
      checkAll("reset", 1'b0, 4'b0000, 72'd0, 1'b1, 2'd0, 1'b1, 16'd0);
      reset = 1'b1;
      #10;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy, vecs[i].bw, vecs[i].fl);
         checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ectrl, vecs[i].edata,
                  vecs[i].chkData, vecs[i].eocc, vecs[i].erdy, vecs[i].ecnt);
      end

      // Asynchronous reset between edges while two entries are held.
      applyStimulus(1, 4'b1110, DH, 0, 0, 0);
      checkAll("prefill", 1'b1, 4'b0101, DG, 1'b1, 2'd2, 1'b0, 16'd2);
      #2;
      reset = 1'b0;
      #1;
      checkAll("async_rst", 1'b0, 4'b0000, 72'd0, 1'b1, 2'd0, 1'b1, 16'd0);
      inValid = 1'b0;
      #3;
      reset = 1'b1;
      #2;
      applyStimulus(1, 4'b1001, DI, 1, 0, 0);
      checkAll("post_rst", 1'b1, 4'b1001, DI, 1'b1, 2'd1, 1'b1, 16'd0);
      applyStimulus(0, 4'b0000, DI, 1, 0, 0);
      checkAll("drain", 1'b0, 4'b0000, DI, 1'b0, 2'd0, 1'b1, 16'd0);

      // Narrow counter saturation on the second instance.
      inValid2 = 1'b1;
      inCtrl2  = 4'b0111;
      inData2  = DA;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(0, 4'b0000, DI, 0, 0, 0);
         if (i == 1) inData2 = DB;
         if (i == 3) checkOutput("sat_cnt_early", 72'(stallCnt2), 72'd1);
      end
      checkOutput("sat_cnt_final", 72'(stallCnt2), 72'd3);
      checkOutput("sat_occ", 72'(occupancy2), 72'd2);
      checkOutput("sat_ready", 72'(inReady2), 72'd0);
      checkOutput("sat_valid", 72'(outValid2), 72'd1);
      checkOutput("sat_ctrl", 72'(outCtrl2), 72'b0111);
      checkOutput("sat_data", outData2, DA);
      inValid2 = 1'b0;

      // Randomized traffic against the FIFO model from a fresh reset.
      reset = 1'b0;
      #4;
      reset = 1'b1;
      modelQ.delete();
      modelCnt = 16'd0;
      for (int n = 0; n < 1500; n++) begin
         r    = {$urandom(), $urandom(), $urandom()};
         data = r[71:0];
         ctrl = 4'($urandom_range(15, 0));
         iv   = ($urandom_range(3, 0) != 0);
         ordy = ($urandom_range(1, 0) != 0);
         bw   = ($urandom_range(7, 0) == 0);
         fl   = ($urandom_range(31, 0) == 0);
         applyStimulus(iv, ctrl, data, ordy, bw, fl);
         modelStep(iv, ctrl, data, ordy, bw, fl);
         head = (modelQ.size() > 0) ? modelQ[0] : 76'd0;
         checkAll($sformatf("rand%0d", n), modelQ.size() > 0, head[75:72], head[71:0],
                  modelQ.size() > 0, 2'(modelQ.size()), modelQ.size() < 2, modelCnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 72, width of the non-gated payload (ALU result, store data, rd, funct3).
REQ-002 SHALL have parameter CTRL_W, default 4, width of control bits (reg write enable, mem-to-reg select, mem read, mem write), gated to zero when invalid.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 IN_VALID  in  1  upstream stage holds a valid instruction.
REQ-007 IN_READY  out  1  block can accept; driven only from registered state.
REQ-008 IN_CTRL  in  CTRL_W  upstream control bits.
REQ-009 IN_DATA  in  DATA_W  upstream payload.
REQ-010 OUT_VALID  out  1  downstream entry valid.
REQ-011 OUT_READY  in  1  downstream can consume.
REQ-012 OUT_CTRL  out  CTRL_W  head-entry control, forced zero when OUT_VALID=0.
REQ-013 OUT_DATA  out  DATA_W  head-entry payload, not gated.
REQ-014 BUSYWAIT  in  1  global memory stall; freezes the block.
REQ-015 FLUSH  in  1  synchronous discard of all held entries.
REQ-016 OCCUPANCY  out  2  number of held entries (0..2).
REQ-017 STALL_CNT  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 Storage SHALL be two entries, a main register (head) and a skid register, in FIFO order; states EMPTY, ONE, TWO.
REQ-019 accept = IN_VALID & IN_READY & !BUSYWAIT & !FLUSH; pop = OUT_VALID & OUT_READY & !BUSYWAIT & !FLUSH.
REQ-020 IN_READY SHALL be 1 in EMPTY and ONE and 0 in TWO, regardless of BUSYWAIT.
REQ-021 EMPTY: accept -> ONE, main loads input; otherwise stay.
REQ-022 ONE: accept & !pop -> TWO, skid loads input; pop & !accept -> EMPTY; accept & pop -> ONE, main loads input; neither -> stay.
REQ-023 TWO: pop -> ONE, main loads skid; otherwise stay (accept impossible).
REQ-024 Latency SHALL be one cycle: an entry accepted at edge k appears on OUT_* after edge k when the block was EMPTY.
REQ-025 FLUSH=1 at an edge SHALL force EMPTY, even with BUSYWAIT=1 or accept/pop pending; data registers MAY retain stale values.
REQ-026 BUSYWAIT=1 without FLUSH SHALL hold state, both entries, and outputs unchanged.
REQ-027 OUT_VALID = (state != EMPTY); OCCUPANCY = 0/1/2 for EMPTY/ONE/TWO.
REQ-028 STALL_CNT SHALL increment by 1 on each edge where IN_VALID=1 and accept=0 and FLUSH=0, and saturate at all-ones.
REQ-029 Entries SHALL never be dropped or duplicated: output order equals accept order.

Reset
REQ-030 RESET=0 SHALL immediately force state EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, skid contents=0, OCCUPANCY=0, STALL_CNT=0, IN_READY=1.
REQ-031 Reset asserted mid-operation SHALL discard all held entries; first accept after release SHALL behave as from EMPTY.

Structure
REQ-032 State encoding (EMPTY=0, ONE=1, TWO=2) and the default widths SHALL live in the shared pipeline package.
REQ-033 The saturating counter SHALL be a sub-module sat_counter, parametrised by CNT_W.

Verification
REQ-034 Reset release, IN_VALID=1, IN_CTRL=4'b1011, IN_DATA=A, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_CTRL=4'b1011, OUT_DATA=A, OCCUPANCY=1.
REQ-035 Accept A, B with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, STALL_CNT increments each further cycle IN_VALID=1; raise OUT_READY -> A then B, in order.
REQ-036 OCCUPANCY=2, BUSYWAIT=1 for 5 cycles with OUT_READY=1 -> outputs and OCCUPANCY unchanged; BUSYWAIT=0 -> A popped next edge.
REQ-037 OCCUPANCY=2, FLUSH=1 with BUSYWAIT=1 for one cycle -> OUT_VALID=0, OUT_CTRL=0, OCCUPANCY=0, IN_READY=1.
REQ-038 CNT_W=2, hold IN_VALID=1, OUT_READY=0 for 8 cycles -> STALL_CNT saturates at 3.
REQ-039 RESET=0 asserted between edges while OCCUPANCY=2 -> outputs zero immediately, before the next CLK edge.
